// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the shared memory port and the arbiter.
// The arbiter uses the slave view; the stages and the memory together form the master view.
interface imem_dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [DW-1:0] if_rdata;
  logic          if_ready;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_rdata, if_ready,
    output dm_rdata, dm_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output if_req, if_addr, if_flush,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_rdata, if_ready,
    input  dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// MEM normally wins; IF is forced through after STARVE_LIMIT consecutive losses.
module imem_dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  imem_dmem_arbiter_if.slave bus
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic          grant;
  logic          grant_dm;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic          kill;
  logic          kill_now;
  logic          last_wait;
  logic          owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A flush in IDLE means the IF address is stale, so IF cannot win that cycle.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_dm   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.if_req && !bus.if_flush && starve_cnt == SW'(STARVE_LIMIT)) begin
          grant = 1'b1;
        end else if (bus.dm_req) begin
          grant    = 1'b1;
          grant_dm = 1'b1;
        end else if (bus.if_req && !bus.if_flush) begin
          grant = 1'b1;
        end
        if (grant) state_next = ISSUE;
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (count == CW'(1)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // kill_now also covers a flush arriving in the capture or response cycle itself.
  assign kill_now  = kill | (bus.if_flush && !owner_q && state != IDLE);
  assign last_wait = (state == WAIT) && (count == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      starve_cnt <= '0;
      kill       <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (grant) begin
        owner_q <= grant_dm;
        addr_q  <= grant_dm ? bus.dm_addr : bus.if_addr;
        we_q    <= grant_dm & bus.dm_we;
        if (grant_dm) wdata_q <= bus.dm_wdata;
        if (!grant_dm) begin
          starve_cnt <= '0;
        end else if (bus.if_req && starve_cnt != SW'(STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end

      if (state == ISSUE)     count <= CW'(LATENCY);
      else if (state == WAIT) count <= count - CW'(1);

      if (last_wait && !we_q) begin
        if (owner_q)        dm_rdata_q <= bus.mem_rdata;
        else if (!kill_now) if_rdata_q <= bus.mem_rdata;
      end

      kill <= (state_next != IDLE) ? kill_now : 1'b0;
    end
  end

  assign bus.mem_en    = (state == ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.owner     = owner_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ready  = (state == RESP) && !owner_q && !kill_now;
  assign bus.dm_ready  = (state == RESP) && owner_q;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: single-transaction vector table plus
// contention, starvation, flush, reset and LATENCY=3 sequences.
module tb_imem_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  imem_dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
  imem_dmem_arbiter_if #(.AW(32), .DW(32)) bus3 ();

  imem_dmem_arbiter #(.AW(32), .DW(32), .LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  imem_dmem_arbiter #(.AW(32), .DW(32), .LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;
    logic        exp_owner;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    bus.if_req = 1'b0;  bus.if_addr = '0;  bus.if_flush = 1'b0;
    bus.dm_req = 1'b0;  bus.dm_we = 1'b0;  bus.dm_addr = '0;
    bus.dm_wdata = '0;  bus.mem_rdata = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.if_req    = v.if_req;
    bus.if_addr   = v.if_addr;
    bus.if_flush  = 1'b0;
    bus.dm_req    = v.dm_req;
    bus.dm_we     = v.dm_we;
    bus.dm_addr   = v.dm_addr;
    bus.dm_wdata  = v.dm_wdata;
    bus.mem_rdata = v.mem_rdata;
  endtask

  task automatic waitMemEn(input int limit, output logic found);
    found = 1'b0;
    for (int n = 0; n < limit && !found; n++) begin
      tick();
      if (bus.mem_en) found = 1'b1;
    end
  endtask

  task automatic waitIfReady(input int limit, output logic found);
    found = 1'b0;
    for (int n = 0; n < limit && !found; n++) begin
      tick();
      if (bus.if_ready) found = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;
    int   pulses;

    vecs[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2002_0001,
                1'b0, 1'b0, 32'h40, 32'h2002_0001, 32'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h1234_5678,
                1'b1, 1'b0, 32'h200, 32'h2002_0001, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
                1'b1, 1'b1, 32'h100, 32'h2002_0001, 32'h1234_5678};
    vecs[3] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D,
                1'b0, 1'b0, 32'h44, 32'hCAFE_F00D, 32'h1234_5678};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0, 32'h0BAD_F00D,
                1'b1, 1'b0, 32'h104, 32'hCAFE_F00D, 32'h0BAD_F00D};

    rst = 1'b1;
    idleInputs();
    bus3.if_req = 1'b0;  bus3.if_addr = '0;  bus3.if_flush = 1'b0;
    bus3.dm_req = 1'b0;  bus3.dm_we = 1'b0;  bus3.dm_addr = '0;
    bus3.dm_wdata = '0;  bus3.mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst if_rdata", bus.if_rdata, 32'h0);
    checkOutput("rst if_ready", bus.if_ready, 32'h0);
    checkOutput("rst dm_rdata", bus.dm_rdata, 32'h0);
    checkOutput("rst dm_ready", bus.dm_ready, 32'h0);
    checkOutput("rst mem_en", bus.mem_en, 32'h0);
    checkOutput("rst mem_we", bus.mem_we, 32'h0);
    checkOutput("rst mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rst mem_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst busy", bus.busy, 32'h0);
    checkOutput("rst owner", bus.owner, 32'h0);
    checkOutput("rst dut3 busy", bus3.busy, 32'h0);

    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("row%0d mem_en T+1", i), bus.mem_en, 32'h1);
      checkOutput($sformatf("row%0d owner", i), bus.owner, 32'(vecs[i].exp_owner));
      checkOutput($sformatf("row%0d mem_we", i), bus.mem_we, 32'(vecs[i].exp_we));
      checkOutput($sformatf("row%0d mem_addr", i), bus.mem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_we) checkOutput($sformatf("row%0d mem_wdata", i), bus.mem_wdata, vecs[i].dm_wdata);
      tick();
      checkOutput($sformatf("row%0d mem_en T+2", i), bus.mem_en, 32'h0);
      checkOutput($sformatf("row%0d early ready", i), 32'(bus.if_ready | bus.dm_ready), 32'h0);
      tick();
      checkOutput($sformatf("row%0d if_ready", i), bus.if_ready, 32'(!vecs[i].exp_owner));
      checkOutput($sformatf("row%0d dm_ready", i), bus.dm_ready, 32'(vecs[i].exp_owner));
      checkOutput($sformatf("row%0d if_rdata", i), bus.if_rdata, vecs[i].exp_if_rdata);
      checkOutput($sformatf("row%0d dm_rdata", i), bus.dm_rdata, vecs[i].exp_dm_rdata);
      checkOutput($sformatf("row%0d busy RESP", i), bus.busy, 32'h1);
      idleInputs();
      tick();
      checkOutput($sformatf("row%0d busy after", i), bus.busy, 32'h0);
    end

    $display("[TB] contention: MEM store beats IF");
    bus.if_req = 1'b1;  bus.if_addr = 32'h80;
    bus.dm_req = 1'b1;  bus.dm_we = 1'b1;  bus.dm_addr = 32'h100;  bus.dm_wdata = 32'hDEAD_BEEF;
    bus.mem_rdata = 32'h7777_8888;
    tick();
    checkOutput("cont owner", bus.owner, 32'h1);
    checkOutput("cont mem_we", bus.mem_we, 32'h1);
    checkOutput("cont mem_addr", bus.mem_addr, 32'h100);
    checkOutput("cont mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    checkOutput("cont starve 1", dut.starve_cnt, 32'h1);
    tick();
    tick();
    checkOutput("cont dm_ready", bus.dm_ready, 32'h1);
    checkOutput("cont if_ready", bus.if_ready, 32'h0);
    checkOutput("cont dm_rdata kept", bus.dm_rdata, 32'h0BAD_F00D);
    bus.dm_req = 1'b0;  bus.dm_we = 1'b0;
    tick();
    checkOutput("cont busy T+4", bus.busy, 32'h0);
    tick();
    checkOutput("cont IF mem_en", bus.mem_en, 32'h1);
    checkOutput("cont IF owner", bus.owner, 32'h0);
    checkOutput("cont IF addr", bus.mem_addr, 32'h80);
    checkOutput("cont IF mem_we", bus.mem_we, 32'h0);
    checkOutput("cont starve 0", dut.starve_cnt, 32'h0);
    tick();
    tick();
    checkOutput("cont IF ready", bus.if_ready, 32'h1);
    checkOutput("cont IF rdata", bus.if_rdata, 32'h7777_8888);
    idleInputs();
    tick();

    $display("[TB] starvation limit");
    bus.if_req = 1'b1;  bus.if_addr = 32'h90;
    bus.dm_req = 1'b1;  bus.dm_we = 1'b0;  bus.dm_addr = 32'h180;
    bus.mem_rdata = 32'h1357_2468;
    for (int g = 0; g < 5; g++) begin
      waitMemEn(20, found);
      checkOutput($sformatf("starve grant%0d seen", g), 32'(found), 32'h1);
      checkOutput($sformatf("starve grant%0d owner", g), bus.owner, (g < 4) ? 32'h1 : 32'h0);
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    waitIfReady(10, found);
    checkOutput("starve if_ready seen", 32'(found), 32'h1);
    checkOutput("starve if_rdata", bus.if_rdata, 32'h1357_2468);
    checkOutput("starve dm_rdata", bus.dm_rdata, 32'h1357_2468);
    tick();
    checkOutput("starve idle", bus.busy, 32'h0);

    $display("[TB] flush during WAIT");
    pulses = 0;
    bus.if_req = 1'b1;  bus.if_addr = 32'h48;  bus.mem_rdata = 32'h1111_2222;
    tick();
    if (bus.mem_en) pulses++;
    tick();
    if (bus.mem_en) pulses++;
    bus.if_flush = 1'b1;
    bus.if_req   = 1'b0;
    tick();
    if (bus.mem_en) pulses++;
    bus.if_flush = 1'b0;
    checkOutput("flush if_ready", bus.if_ready, 32'h0);
    checkOutput("flush busy RESP", bus.busy, 32'h1);
    checkOutput("flush if_rdata kept", bus.if_rdata, 32'h1357_2468);
    tick();
    if (bus.mem_en) pulses++;
    checkOutput("flush busy clear", bus.busy, 32'h0);
    checkOutput("flush no late ready", bus.if_ready, 32'h0);
    checkOutput("flush mem_en pulses", 32'(pulses), 32'h1);
    bus.if_req = 1'b1;  bus.if_addr = 32'h4C;  bus.mem_rdata = 32'h3333_4444;
    tick();
    tick();
    tick();
    checkOutput("post-flush if_ready", bus.if_ready, 32'h1);
    checkOutput("post-flush if_rdata", bus.if_rdata, 32'h3333_4444);
    idleInputs();
    tick();

    $display("[TB] flush in IDLE");
    bus.if_req = 1'b1;  bus.if_addr = 32'h50;  bus.if_flush = 1'b1;
    tick();
    checkOutput("idle flush no grant", bus.busy, 32'h0);
    checkOutput("idle flush mem_en", bus.mem_en, 32'h0);
    bus.if_req = 1'b1;  bus.if_flush = 1'b1;
    bus.dm_req = 1'b1;  bus.dm_we = 1'b0;  bus.dm_addr = 32'h140;  bus.mem_rdata = 32'h9999_AAAA;
    tick();
    bus.if_req = 1'b0;  bus.if_flush = 1'b0;
    checkOutput("idle flush MEM mem_en", bus.mem_en, 32'h1);
    checkOutput("idle flush MEM owner", bus.owner, 32'h1);
    tick();
    tick();
    checkOutput("idle flush dm_ready", bus.dm_ready, 32'h1);
    checkOutput("idle flush dm_rdata", bus.dm_rdata, 32'h9999_AAAA);
    idleInputs();
    tick();

    $display("[TB] reset during WAIT");
    bus.dm_req = 1'b1;  bus.dm_we = 1'b0;  bus.dm_addr = 32'h1C0;  bus.mem_rdata = 32'h55AA_55AA;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst busy", bus.busy, 32'h0);
    checkOutput("midrst mem_en", bus.mem_en, 32'h0);
    checkOutput("midrst dm_ready", bus.dm_ready, 32'h0);
    checkOutput("midrst dm_rdata", bus.dm_rdata, 32'h0);
    checkOutput("midrst if_rdata", bus.if_rdata, 32'h0);
    checkOutput("midrst owner", bus.owner, 32'h0);
    checkOutput("midrst mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    idleInputs();
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.dm_ready) pulses++;
    end
    checkOutput("midrst no dm_ready", 32'(pulses), 32'h0);

    $display("[TB] LATENCY=3 load");
    bus3.dm_req = 1'b1;  bus3.dm_we = 1'b0;  bus3.dm_addr = 32'h300;  bus3.mem_rdata = 32'hA000_0000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput($sformatf("lat3 mem_en T+%0d", k), bus3.mem_en, (k == 1) ? 32'h1 : 32'h0);
      checkOutput($sformatf("lat3 dm_ready T+%0d", k), bus3.dm_ready, (k == 5) ? 32'h1 : 32'h0);
      if (k == 5) begin
        checkOutput("lat3 dm_rdata", bus3.dm_rdata, 32'hA000_0004);
        bus3.dm_req = 1'b0;
      end
      bus3.mem_rdata = 32'hA000_0000 + 32'(k);
    end
    tick();
    checkOutput("lat3 idle", bus3.busy, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
